// File: rtl/sram_uart_dump.sv
// Streams WORD_COUNT 16-bit SRAM words out a byte-wide valid/ready UART port, high byte first.
// Define PPM_HEADER_EN to prefix the stream with a 15-byte binary PPM header.
module sram_uart_dump #(
  parameter int unsigned WORD_COUNT   = 115200,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Base_address,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic [7:0]  Tx_data,
  output logic        Tx_valid,
  input  logic        Tx_ready,
  output logic        Busy,
  output logic        Done
);

  localparam logic [16:0] LastWord = 17'(WORD_COUNT - 1);
  localparam logic [1:0]  WaitLast = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef PPM_HEADER_EN
    S_HEADER,
`endif
    S_ISSUE,
    S_WAIT,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [17:0] base_q, base_d;
  logic [16:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [17:0] addr_q, addr_d;
  logic [1:0]  wait_q, wait_d;

`ifdef PPM_HEADER_EN
  logic [3:0] hdr_idx_q, hdr_idx_d;

  // "P6\n320 240\n255\n"
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    unique case (idx)
      4'd0:    hdr_byte = 8'h50;
      4'd1:    hdr_byte = 8'h36;
      4'd2:    hdr_byte = 8'h0A;
      4'd3:    hdr_byte = 8'h33;
      4'd4:    hdr_byte = 8'h32;
      4'd5:    hdr_byte = 8'h30;
      4'd6:    hdr_byte = 8'h20;
      4'd7:    hdr_byte = 8'h32;
      4'd8:    hdr_byte = 8'h34;
      4'd9:    hdr_byte = 8'h30;
      4'd10:   hdr_byte = 8'h0A;
      4'd11:   hdr_byte = 8'h32;
      4'd12:   hdr_byte = 8'h35;
      4'd13:   hdr_byte = 8'h35;
      4'd14:   hdr_byte = 8'h0A;
      default: hdr_byte = 8'h00;
    endcase
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    addr_d   = addr_q;
    wait_d   = wait_q;
`ifdef PPM_HEADER_EN
    hdr_idx_d = hdr_idx_q;
`endif
    Tx_valid = 1'b0;
    Tx_data  = 8'h00;
    Done     = 1'b0;
    Busy     = (state_q != S_IDLE) && (state_q != S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          base_d = Base_address;
          cnt_d  = '0;
`ifdef PPM_HEADER_EN
          hdr_idx_d = '0;
          state_d   = S_HEADER;
`else
          state_d = S_ISSUE;
`endif
        end
      end
`ifdef PPM_HEADER_EN
      S_HEADER: begin
        Tx_valid = 1'b1;
        Tx_data  = hdr_byte(hdr_idx_q);
        if (Tx_ready) begin
          if (hdr_idx_q == 4'd14) state_d = S_ISSUE;
          else                    hdr_idx_d = hdr_idx_q + 4'd1;
        end
      end
`endif
      S_ISSUE: begin
        // 18-bit add wraps the address space naturally
        addr_d  = base_q + 18'(cnt_q);
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WaitLast) begin
          hold_d  = SRAM_read_data;
          state_d = S_HIGH;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_HIGH: begin
        Tx_valid = 1'b1;
        Tx_data  = hold_q[15:8];
        if (Tx_ready) state_d = S_LOW;
      end
      S_LOW: begin
        Tx_valid = 1'b1;
        Tx_data  = hold_q[7:0];
        if (Tx_ready) begin
          cnt_d   = cnt_q + 17'd1;
          state_d = (cnt_q == LastWord) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address is presented during S_ISSUE itself and held afterwards
  assign SRAM_address = addr_d;
  assign SRAM_we_n    = 1'b1;

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
`ifdef PPM_HEADER_EN
      hdr_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
`ifdef PPM_HEADER_EN
      hdr_idx_q <= hdr_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_uart_dump.sv
// Self-checking bench for sram_uart_dump: byte-stream model built from SRAM contents,
// per-cycle handshake/stability checks, and directed abort/wrap/restart scenarios.
module tb_sram_uart_dump;

  localparam int unsigned WC = 4;
  localparam int unsigned RL = 2;
`ifdef PPM_HEADER_EN
  localparam int HDR = 15;
`else
  localparam int HDR = 0;
`endif

  logic        Clock_50 = 1'b0;
  logic        Reset;
  logic        Start;
  logic [17:0] Base_address;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [7:0]  Tx_data;
  logic        Tx_valid;
  logic        Tx_ready = 1'b0;
  logic        Busy;
  logic        Done;

  always #5 Clock_50 = ~Clock_50;

  sram_uart_dump #(
    .WORD_COUNT  (WC),
    .READ_LATENCY(RL)
  ) dut (
    .Clock_50      (Clock_50),
    .Reset         (Reset),
    .Start         (Start),
    .Base_address  (Base_address),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .SRAM_read_data(SRAM_read_data),
    .Tx_data       (Tx_data),
    .Tx_valid      (Tx_valid),
    .Tx_ready      (Tx_ready),
    .Busy          (Busy),
    .Done          (Done)
  );

  // SRAM: data for the address seen in cycle t appears during cycle t+RL
  logic [15:0] mem [0:262143];
  logic [15:0] pipe [RL];
  always @(posedge Clock_50) begin
    pipe[0] <= mem[SRAM_address];
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign SRAM_read_data = pipe[RL-1];

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [17:0] addr_log[$];
  int          exp_idx = 0;
  int          done_cnt = 0;
  logic        rdy_random = 1'b0;
  logic [17:0] last_addr = '0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  string       hdr_s = "P6\n320 240\n255\n";

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 8'h00;
  endfunction

  function automatic logic [17:0] addr_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 18'h15555;
  endfunction

  always @(posedge Clock_50) begin
    #1;
    Tx_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Compare process: inputs are stable here, so valid&ready means a transfer at the next edge
  always @(negedge Clock_50) begin
    if (!Reset) begin
      check("we_n", 32'(SRAM_we_n), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(Tx_valid), 32'd1);
        check("stall_data", 32'(Tx_data), 32'(prev_data));
      end
      if (Tx_valid) check("busy_with_valid", 32'(Busy), 32'd1);
      if (Tx_valid && Tx_ready) begin
        got_q.push_back(Tx_data);
        if (exp_idx < exp_q.size()) check("byte", 32'(Tx_data), 32'(exp_q[exp_idx]));
        else check("extra_byte", 32'(exp_idx), 32'(exp_q.size()));
        exp_idx++;
      end
      if (Done) begin
        done_cnt++;
        check("busy_at_done", 32'(Busy), 32'd0);
        check("bytes_at_done", 32'(exp_idx), 32'(exp_q.size()));
      end
      if (SRAM_address != last_addr) addr_log.push_back(SRAM_address);
    end
    last_addr  = SRAM_address;
    prev_stall = Tx_valid && !Tx_ready && !Reset;
    prev_data  = Tx_data;
  end

  task automatic build_expect(input logic [17:0] base);
    logic [17:0] a;
    exp_q.delete();
    got_q.delete();
    addr_log.delete();
`ifdef PPM_HEADER_EN
    for (int i = 0; i < hdr_s.len(); i++) exp_q.push_back(hdr_s[i]);
`endif
    for (int i = 0; i < WC; i++) begin
      a = base + 18'(i);
      exp_q.push_back(mem[a][15:8]);
      exp_q.push_back(mem[a][7:0]);
    end
    exp_idx  = 0;
    done_cnt = 0;
  endtask

  task automatic run_dump(input logic [17:0] base, input int glitch_at);
    build_expect(base);
    @(posedge Clock_50); #1;
    Start = 1'b1;
    Base_address = base;
    @(posedge Clock_50); #1;
    Start = 1'b0;
    Base_address = 18'h2AAAA;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      @(posedge Clock_50); #1;
      if (c == glitch_at) begin
        Start = 1'b1;
        Base_address = 18'h3FFFE;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
    if (done_cnt == 0) check("done_timeout", 32'(done_cnt), 32'd1);
    repeat (6) @(posedge Clock_50);
    #1;
    check("done_count", 32'(done_cnt), 32'd1);
    check("stream_len", 32'(got_q.size()), 32'(HDR + 2 * WC));
  endtask

  task automatic pin_base100(input string tag);
    check({tag, "_byte0"}, 32'(got_at(HDR)), 32'h12);
    check({tag, "_byte3"}, 32'(got_at(HDR + 3)), 32'h78);
    check({tag, "_byte7"}, 32'(got_at(HDR + 7)), 32'hF0);
`ifdef PPM_HEADER_EN
    check({tag, "_hdr0"}, 32'(got_at(0)), 32'h50);
    check({tag, "_hdr14"}, 32'(got_at(14)), 32'h0A);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Base_address = '0;
    for (int i = 0; i < 262144; i++) mem[i] = 16'(i * 37 + 5);
    mem[18'h100] = 16'h1234;
    mem[18'h101] = 16'h5678;
    mem[18'h102] = 16'h9ABC;
    mem[18'h103] = 16'hDEF0;
    mem[18'h3FFFE] = 16'hA1B2;
    mem[18'h3FFFF] = 16'hC3D4;
    mem[18'h00000] = 16'hE5F6;
    mem[18'h00001] = 16'h0718;

    repeat (3) @(posedge Clock_50);
    @(negedge Clock_50);
    check("rst_addr", 32'(SRAM_address), 32'h0);
    check("rst_we_n", 32'(SRAM_we_n), 32'd1);
    check("rst_tx_data", 32'(Tx_data), 32'h0);
    check("rst_tx_valid", 32'(Tx_valid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    @(posedge Clock_50); #1;
    Reset = 1'b0;

    // Basic dump, Tx_ready held high
    run_dump(18'h100, -1);
    pin_base100("basic");

    // Random back-pressure
    rdy_random = 1'b1;
    run_dump(18'h100, -1);
    pin_base100("random_ready");
    rdy_random = 1'b0;

    // Address wrap at top of SRAM
    run_dump(18'h3FFFE, -1);
    check("wrap_addr_n", 32'(addr_log.size()), 32'd4);
    check("wrap_addr0", 32'(addr_at(0)), 32'h3FFFE);
    check("wrap_addr1", 32'(addr_at(1)), 32'h3FFFF);
    check("wrap_addr2", 32'(addr_at(2)), 32'h00000);
    check("wrap_addr3", 32'(addr_at(3)), 32'h00001);
    check("wrap_byte0", 32'(got_at(HDR)), 32'hA1);
    check("wrap_byte5", 32'(got_at(HDR + 5)), 32'hF6);

    // Abort after the 7th pixel byte; Start during Reset must be discarded
    build_expect(18'h100);
    @(posedge Clock_50); #1;
    Start = 1'b1;
    Base_address = 18'h100;
    @(posedge Clock_50); #1;
    Start = 1'b0;
    for (int c = 0; c < 500 && exp_idx < HDR + 7; c++) begin
      @(posedge Clock_50); #1;
    end
    check("abort_reached", 32'(exp_idx), 32'(HDR + 7));
    Reset = 1'b1;
    Start = 1'b1;
    @(posedge Clock_50); #1;
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge Clock_50);
    check("abort_tx_valid", 32'(Tx_valid), 32'd0);
    check("abort_busy", 32'(Busy), 32'd0);
    repeat (20) @(posedge Clock_50);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_len", 32'(got_q.size()), 32'(HDR + 7));
    check("abort_busy_later", 32'(Busy), 32'd0);

    // Replay after abort starts from byte 0
    run_dump(18'h100, -1);
    pin_base100("replay");

    // Start with another base mid-dump is ignored
    run_dump(18'h100, 8);
    pin_base100("restart_ignored");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_uart_dump.md
SRAM_UART_DUMP -- requirements
Module: sram_uart_dump

Interface
REQ-001 Parameter WORD_COUNT, default 115200, number of 16-bit SRAM words per dump (320x240 RGB, 2 bytes/word); legal range 1..2^17-1.
REQ-002 Parameter READ_LATENCY, default 2, cycles from SRAM_address drive to valid SRAM_read_data; legal range 1..3.
REQ-003 Clock_50  in  1  sole clock; all logic on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  one-cycle request to begin a dump.
REQ-006 Base_address  in  18  first SRAM word of the image; latched on accepted Start.
REQ-007 SRAM_address  out  18  read address to SRAM controller.
REQ-008 SRAM_we_n  out  1  write enable to SRAM controller, active-low; constant 1.
REQ-009 SRAM_read_data  in  16  read data, valid READ_LATENCY cycles after address.
REQ-010 Tx_data  out  8  byte to UART transmitter.
REQ-011 Tx_valid  out  1  Tx_data holds a byte to transfer.
REQ-012 Tx_ready  in  1  transmitter accepts byte this cycle.
REQ-013 Busy  out  1  high from accepted Start until Done.
REQ-014 Done  out  1  one-cycle pulse after final byte accepted.

Function
REQ-015 FSM states: S_IDLE, S_HEADER, S_ISSUE, S_WAIT, S_HIGH, S_LOW, S_DONE.
REQ-016 S_IDLE: Start=1 latches Base_address, clears word counter, sets Busy next cycle; next state S_HEADER if header compiled in, else S_ISSUE.
REQ-017 Start while Busy=1 is ignored; Base_address changes while Busy=1 have no effect.
REQ-018 Byte transfer occurs exactly on a cycle with Tx_valid=1 and Tx_ready=1; Tx_data is stable while Tx_valid=1 and Tx_ready=0.
REQ-019 Tx_valid is not conditioned on Tx_ready; Tx_ready asserted while Tx_valid=0 is ignored.
REQ-020 S_ISSUE: drive SRAM_address = latched base + word counter, modulo 2^18 (wraps 3FFFF to 00000); go to S_WAIT.
REQ-021 S_WAIT: count READ_LATENCY-1 further cycles, then capture SRAM_read_data into a 16-bit holding register; go to S_HIGH.
REQ-022 S_HIGH: Tx_valid=1, Tx_data = holding[15:8]; on transfer go to S_LOW, Tx_valid remaining 1 with next byte the following cycle.
REQ-023 S_LOW: Tx_data = holding[7:0]; on transfer increment counter; if counter was WORD_COUNT-1 go to S_DONE, else S_ISSUE with Tx_valid=0.
REQ-024 S_DONE: Done=1 one cycle, Busy=0 same cycle, return to S_IDLE; Start in S_DONE is ignored.
REQ-025 Byte order: word i high byte, then low byte, i ascending from 0; total stream = header bytes + 2*WORD_COUNT.
REQ-026 SRAM_address holds its last value outside S_ISSUE; SRAM_we_n never 0.

Reset
REQ-027 Reset=1 at any clock edge forces S_IDLE, aborting any dump with no Done pulse.
REQ-028 Reset values: SRAM_address=0, SRAM_we_n=1, Tx_data=0, Tx_valid=0, Busy=0, Done=0, counter=0, holding=0.
REQ-029 Reset and Start in the same cycle: Reset wins, Start discarded.

Configuration
REQ-030 Macro PPM_HEADER_EN defined: S_HEADER emits 15 ASCII bytes "P6",0A,"320 240",0A,"255",0A (50 36 0A 33 32 30 20 32 34 30 0A 32 35 35 0A) using REQ-018 handshake, then S_ISSUE.
REQ-031 Macro PPM_HEADER_EN undefined: S_HEADER and its byte ROM absent; stream is raw pixel bytes only.

Verification
REQ-032 Header on, WORD_COUNT=4, Base=0x100, SRAM[0x100..0x103]=1234,5678,9ABC,DEF0, Tx_ready=1 -> 15 header bytes then 12 34 56 78 9A BC DE F0, one Done pulse, Busy low with Done.
REQ-033 Tx_ready toggled pseudo-randomly (50%) -> identical byte sequence, Tx_data never changes while Tx_valid=1 and Tx_ready=0.
REQ-034 Base=0x3FFFE, WORD_COUNT=4 -> addresses 3FFFE,3FFFF,00000,00001 in order.
REQ-035 Reset asserted after 7th pixel byte -> Tx_valid=0, Busy=0 next cycle, no Done; new Start replays full stream from byte 0.
REQ-036 Start pulsed during dump with different Base -> stream unchanged, exactly one Done.
REQ-037 Header off, WORD_COUNT=115200 -> exactly 230400 bytes, first byte = SRAM[Base][15:8], last = SRAM[Base+115199][7:0].
